// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone (pipelined) arbiter: round-robin ownership, combinational
// owner<->slave muxing and a per-strobe watchdog that aborts silent transfers.

module wb_rr_master_port #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  owned,
    input  logic                  aborting,
    input  logic                  abort_err,
    input  logic [DATA_WIDTH-1:0] s_dat,
    input  logic                  s_ack,
    input  logic                  s_err,
    input  logic                  s_stall,
    output logic [DATA_WIDTH-1:0] dat,
    output logic                  ack,
    output logic                  err,
    output logic                  stall
);
    always_comb begin
        dat   = '0;
        ack   = 1'b0;
        err   = 1'b0;
        stall = 1'b1;
        if (owned) begin
            dat   = s_dat;
            ack   = s_ack;
            err   = s_err;
            stall = s_stall;
        end else if (aborting) begin
            err = abort_err;
        end
    end
endmodule

module wb_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                  wb_clk,
    input  logic                  wb_rst,
    input  logic                  m0_wb_cyc,
    input  logic                  m0_wb_stb,
    input  logic                  m0_wb_we,
    input  logic [ADDR_WIDTH-1:0] m0_wb_adr,
    input  logic [DATA_WIDTH-1:0] m0_wb_dat_i,
    input  logic [SEL_WIDTH-1:0]  m0_wb_sel,
    output logic [DATA_WIDTH-1:0] m0_wb_dat_o,
    output logic                  m0_wb_ack,
    output logic                  m0_wb_err,
    output logic                  m0_wb_stall,
    input  logic                  m1_wb_cyc,
    input  logic                  m1_wb_stb,
    input  logic                  m1_wb_we,
    input  logic [ADDR_WIDTH-1:0] m1_wb_adr,
    input  logic [DATA_WIDTH-1:0] m1_wb_dat_i,
    input  logic [SEL_WIDTH-1:0]  m1_wb_sel,
    output logic [DATA_WIDTH-1:0] m1_wb_dat_o,
    output logic                  m1_wb_ack,
    output logic                  m1_wb_err,
    output logic                  m1_wb_stall,
    output logic                  s_wb_cyc,
    output logic                  s_wb_stb,
    output logic                  s_wb_we,
    output logic [ADDR_WIDTH-1:0] s_wb_adr,
    output logic [DATA_WIDTH-1:0] s_wb_dat_o,
    output logic [SEL_WIDTH-1:0]  s_wb_sel,
    input  logic [DATA_WIDTH-1:0] s_wb_dat_i,
    input  logic                  s_wb_ack,
    input  logic                  s_wb_err,
    input  logic                  s_wb_stall,
    output logic [1:0]            grant,
    output logic                  timeout
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

    state_t          state;
    logic            rr_ptr;
    logic [WD_W-1:0] wd_cnt;
    logic            abort_owner;

    logic [1:0]                 cyc, stb, we;
    logic [1:0][ADDR_WIDTH-1:0] adr;
    logic [1:0][DATA_WIDTH-1:0] wdat;
    logic [1:0][SEL_WIDTH-1:0]  sel;

    logic [1:0]                 owned, aborting;
    logic [1:0][DATA_WIDTH-1:0] rdat;
    logic [1:0]                 rack, rerr, rstall;

    logic own_valid, own_idx, other_idx, pending, wd_hit;

    assign cyc  = {m1_wb_cyc, m0_wb_cyc};
    assign stb  = {m1_wb_stb, m0_wb_stb};
    assign we   = {m1_wb_we, m0_wb_we};
    assign adr  = {m1_wb_adr, m0_wb_adr};
    assign wdat = {m1_wb_dat_i, m0_wb_dat_i};
    assign sel  = {m1_wb_sel, m0_wb_sel};

    assign own_valid = (state == OWN0) || (state == OWN1);
    assign own_idx   = (state == OWN1);
    assign other_idx = ~own_idx;
    assign owned     = {state == OWN1, state == OWN0};
    assign aborting  = {(state == ABORT) && abort_owner, (state == ABORT) && !abort_owner};
    assign grant     = owned;

    // Only strobes left hanging by the slave count toward the abort.
    assign pending = own_valid && s_wb_stb && !s_wb_ack && !s_wb_err;
    assign wd_hit  = pending && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_comb begin
        s_wb_cyc   = 1'b0;
        s_wb_stb   = 1'b0;
        s_wb_we    = 1'b0;
        s_wb_adr   = '0;
        s_wb_dat_o = '0;
        s_wb_sel   = '0;
        if (own_valid) begin
            s_wb_cyc   = cyc[own_idx];
            s_wb_stb   = stb[own_idx] && cyc[own_idx];
            s_wb_we    = we[own_idx];
            s_wb_adr   = adr[own_idx];
            s_wb_dat_o = wdat[own_idx];
            s_wb_sel   = sel[own_idx];
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_port
        wb_rr_master_port #(.DATA_WIDTH(DATA_WIDTH)) u_port (
            .owned     (owned[g]),
            .aborting  (aborting[g]),
            .abort_err (timeout),
            .s_dat     (s_wb_dat_i),
            .s_ack     (s_wb_ack),
            .s_err     (s_wb_err),
            .s_stall   (s_wb_stall),
            .dat       (rdat[g]),
            .ack       (rack[g]),
            .err       (rerr[g]),
            .stall     (rstall[g])
        );
    end

    assign m0_wb_dat_o = rdat[0];
    assign m0_wb_ack   = rack[0];
    assign m0_wb_err   = rerr[0];
    assign m0_wb_stall = rstall[0];
    assign m1_wb_dat_o = rdat[1];
    assign m1_wb_ack   = rack[1];
    assign m1_wb_err   = rerr[1];
    assign m1_wb_stall = rstall[1];

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            wd_cnt      <= '0;
            abort_owner <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (cyc[0] && cyc[1]) state <= rr_ptr ? OWN1 : OWN0;
                    else if (cyc[0])      state <= OWN0;
                    else if (cyc[1])      state <= OWN1;
                end
                OWN0, OWN1: begin
                    if (!cyc[own_idx]) begin
                        // Release wins over the watchdog; hand straight over if the other waits.
                        rr_ptr <= other_idx;
                        wd_cnt <= '0;
                        state  <= cyc[other_idx] ? (other_idx ? OWN1 : OWN0) : IDLE;
                    end else if (wd_hit) begin
                        state       <= ABORT;
                        abort_owner <= own_idx;
                        timeout     <= 1'b1;
                        wd_cnt      <= '0;
                    end else if (pending) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                ABORT: begin
                    wd_cnt <= '0;
                    if (!cyc[abort_owner]) begin
                        state  <= IDLE;
                        rr_ptr <= ~abort_owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: stimulus queues expected master responses,
// a negedge monitor pops and compares them whenever a master sees ack or err.

module tb_wb_rr_arbiter;
    localparam int AW = 32, DW = 32, SW = 4, TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          mcyc[2], mstb[2], mwe[2];
    logic [AW-1:0] madr[2];
    logic [DW-1:0] mdat[2];
    logic [SW-1:0] msel[2];

    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [AW-1:0] s_adr;
    logic [SW-1:0] s_sel;
    logic          m0_ack, m0_err, m0_stall, m1_ack, m1_err, m1_stall;
    logic          s_cyc, s_stb, s_we, s_ack, s_err, s_stall;
    logic [1:0]    grant;
    logic          timeout;

    logic          slave_en = 1'b1;
    logic          late_ack = 1'b0;
    logic [DW-1:0] slave_rdata = '0;

    assign s_ack   = (s_cyc & s_stb & slave_en) | late_ack;
    assign s_err   = 1'b0;
    assign s_stall = 1'b0;
    assign s_dat_i = slave_rdata;

    wb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(TO)) dut (
        .wb_clk(clk), .wb_rst(rst),
        .m0_wb_cyc(mcyc[0]), .m0_wb_stb(mstb[0]), .m0_wb_we(mwe[0]), .m0_wb_adr(madr[0]),
        .m0_wb_dat_i(mdat[0]), .m0_wb_sel(msel[0]), .m0_wb_dat_o(m0_dat_o),
        .m0_wb_ack(m0_ack), .m0_wb_err(m0_err), .m0_wb_stall(m0_stall),
        .m1_wb_cyc(mcyc[1]), .m1_wb_stb(mstb[1]), .m1_wb_we(mwe[1]), .m1_wb_adr(madr[1]),
        .m1_wb_dat_i(mdat[1]), .m1_wb_sel(msel[1]), .m1_wb_dat_o(m1_dat_o),
        .m1_wb_ack(m1_ack), .m1_wb_err(m1_err), .m1_wb_stall(m1_stall),
        .s_wb_cyc(s_cyc), .s_wb_stb(s_stb), .s_wb_we(s_we), .s_wb_adr(s_adr),
        .s_wb_dat_o(s_dat_o), .s_wb_sel(s_sel), .s_wb_dat_i(s_dat_i),
        .s_wb_ack(s_ack), .s_wb_err(s_err), .s_wb_stall(s_stall),
        .grant(grant), .timeout(timeout)
    );

    typedef struct {
        int          mst;
        logic        is_err;
        logic        chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic exp_t mk(input int m, input logic e, input logic cd, input logic [31:0] d);
        exp_t x;
        x.mst = m; x.is_err = e; x.chk_dat = cd; x.dat = d;
        return x;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard monitor
    logic [1:0]        r_ack, r_err;
    logic [1:0][31:0]  r_dat;
    assign r_ack = {m1_ack, m0_ack};
    assign r_err = {m1_err, m0_err};
    assign r_dat = {m1_dat_o, m0_dat_o};

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (r_ack[g] || r_err[g]) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp_master", 32'(g), 32'hFFFF_FFFF);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("resp_master", 32'(g), 32'(x.mst));
                    chk("resp_err", {31'b0, r_err[g]}, {31'b0, x.is_err});
                    chk("resp_ack", {31'b0, r_ack[g]}, {31'b0, !x.is_err});
                    chk("resp_timeout", {31'b0, timeout}, {31'b0, x.is_err});
                    if (!x.is_err) chk("resp_grant", {30'b0, grant}, (g == 1) ? 32'd2 : 32'd1);
                    if (x.chk_dat) chk("resp_data", r_dat[g], x.dat);
                end
            end
        end
    end

    task automatic run_master(input int m, input int n);
        int  w;
        logic got;
        for (int i = 0; i < n; i++) begin
            mcyc[m] = 1'b1; mstb[m] = 1'b1; mwe[m] = 1'b1;
            madr[m] = 32'h100 + 32'(m); mdat[m] = 32'hF00D_0000 + 32'(i);
            w = 0; got = 1'b0;
            while (!got && w < 50) begin
                smp();
                got = (m == 1) ? !m1_stall : !m0_stall;
                if (!got) begin
                    nxt();
                    w++;
                end
            end
            chk("fair_accept", {31'b0, got}, 32'd1);
            nxt();
            mcyc[m] = 1'b0; mstb[m] = 1'b0;
            nxt();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            mcyc[i] = 0; mstb[i] = 0; mwe[i] = 0; madr[i] = '0; mdat[i] = '0; msel[i] = 4'hF;
        end
        nxt(); nxt();
        smp();
        chk("rst_grant", {30'b0, grant}, 0);
        chk("rst_scyc", {31'b0, s_cyc}, 0);
        chk("rst_stalls", {30'b0, m1_stall, m0_stall}, 32'd3);
        chk("rst_timeout", {31'b0, timeout}, 0);
        nxt();
        rst = 1'b0;

        // single master write
        q.push_back(mk(0, 0, 0, 0));
        mcyc[0] = 1; mstb[0] = 1; mwe[0] = 1; madr[0] = 32'h10; mdat[0] = 32'hDEADBEEF;
        smp();
        chk("t1_grant_before", {30'b0, grant}, 0);
        chk("t1_m0_stall_before", {31'b0, m0_stall}, 1);
        nxt(); smp();
        chk("t1_grant", {30'b0, grant}, 1);
        chk("t1_s_dat", s_dat_o, 32'hDEADBEEF);
        chk("t1_s_adr", s_adr, 32'h10);
        chk("t1_s_we", {31'b0, s_we}, 1);
        chk("t1_ack_pair", {30'b0, s_ack, m0_ack}, 32'd3);
        chk("t1_m1_stall", {31'b0, m1_stall}, 1);
        nxt();
        mcyc[0] = 0; mstb[0] = 0;
        nxt(); smp();
        chk("t1_released", {30'b0, grant}, 0);
        nxt();

        // simultaneous reads from reset
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        q.push_back(mk(0, 0, 1, 32'hA5A50000));
        q.push_back(mk(1, 0, 1, 32'h12345678));
        slave_rdata = 32'hA5A50000;
        mcyc[0] = 1; mstb[0] = 1; mwe[0] = 0; madr[0] = 32'h20;
        mcyc[1] = 1; mstb[1] = 1; mwe[1] = 0; madr[1] = 32'h24;
        nxt(); smp();
        chk("t2_first_grant", {30'b0, grant}, 1);
        chk("t2_m1_dat_zero", m1_dat_o, 0);
        chk("t2_m1_stall", {31'b0, m1_stall}, 1);
        nxt();
        mcyc[0] = 0; mstb[0] = 0;
        slave_rdata = 32'h12345678;
        smp();
        chk("t2_gap_scyc", {31'b0, s_cyc}, 0);
        nxt(); smp();
        chk("t2_second_grant", {30'b0, grant}, 2);
        chk("t2_s_adr", s_adr, 32'h24);
        chk("t2_m0_dat_zero", m0_dat_o, 0);
        nxt();
        mcyc[1] = 0; mstb[1] = 0;
        nxt(); nxt();

        // fairness: 01,10,01,10
        q.push_back(mk(0, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 0));
        fork
            run_master(0, 2);
            run_master(1, 2);
        join
        nxt();
        chk("t3_queue_empty", q.size(), 0);

        // watchdog abort on m1
        slave_en = 1'b0;
        q.push_back(mk(1, 1, 0, 0));
        mcyc[1] = 1; mstb[1] = 1; mwe[1] = 0; madr[1] = 32'h40;
        smp();
        chk("t4_grant_w0", {30'b0, grant}, 0);
        for (int i = 1; i <= 4; i++) begin
            nxt(); smp();
            chk("t4_no_timeout", {31'b0, timeout}, 0);
            chk("t4_no_err", {31'b0, m1_err}, 0);
            chk("t4_grant", {30'b0, grant}, 2);
        end
        nxt(); smp();
        chk("t4_abort_scyc", {31'b0, s_cyc}, 0);
        chk("t4_abort_sstb", {31'b0, s_stb}, 0);
        chk("t4_abort_stall", {31'b0, m1_stall}, 1);
        nxt();
        late_ack = 1'b1;
        q.push_back(mk(0, 0, 0, 0));
        mcyc[0] = 1; mstb[0] = 1; mwe[0] = 1; madr[0] = 32'h50; mdat[0] = 32'h5555AAAA;
        smp();
        chk("t4_late_ack_dropped", {31'b0, m1_ack}, 0);
        chk("t4_err_one_cycle", {31'b0, m1_err}, 0);
        chk("t4_timeout_one_cycle", {31'b0, timeout}, 0);
        chk("t4_scyc_still_low", {31'b0, s_cyc}, 0);
        nxt();
        late_ack = 1'b0; slave_en = 1'b1;
        mcyc[1] = 0; mstb[1] = 0;
        nxt(); smp();
        chk("t4_idle_after_abort", {30'b0, grant}, 0);
        nxt(); smp();
        chk("t4_m0_wins", {30'b0, grant}, 1);
        nxt();
        mcyc[0] = 0; mstb[0] = 0;
        nxt();

        // ack on the boundary cycle
        slave_en = 1'b0;
        q.push_back(mk(0, 0, 0, 0));
        mcyc[0] = 1; mstb[0] = 1; mwe[0] = 0; madr[0] = 32'h60;
        for (int i = 1; i <= 3; i++) begin
            nxt(); smp();
            chk("t5_no_timeout", {31'b0, timeout}, 0);
            chk("t5_no_ack_yet", {31'b0, m0_ack}, 0);
        end
        nxt();
        slave_en = 1'b1;
        smp();
        chk("t5_ack_boundary", {31'b0, m0_ack}, 1);
        chk("t5_no_timeout_ack", {31'b0, timeout}, 0);
        nxt();
        mcyc[0] = 0; mstb[0] = 0;
        smp();
        chk("t5_no_timeout_after", {31'b0, timeout}, 0);
        chk("t5_still_owned", {30'b0, grant}, 1);
        nxt();

        // reset mid-read while m1 owns
        slave_en = 1'b0;
        mcyc[1] = 1; mstb[1] = 1; mwe[1] = 0; madr[1] = 32'h70;
        nxt(); smp();
        chk("t6_m1_owns", {30'b0, grant}, 2);
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        slave_en = 1'b1;
        slave_rdata = 32'hBEEF0080;
        mcyc[0] = 1; mstb[0] = 1; mwe[0] = 0; madr[0] = 32'h80;
        q.push_back(mk(0, 0, 1, 32'hBEEF0080));
        smp();
        chk("t6_rst_grant", {30'b0, grant}, 0);
        chk("t6_rst_scyc", {31'b0, s_cyc}, 0);
        chk("t6_rst_sstb", {31'b0, s_stb}, 0);
        chk("t6_rst_stalls", {30'b0, m1_stall, m0_stall}, 32'd3);
        chk("t6_rst_m1_ack", {31'b0, m1_ack}, 0);
        chk("t6_rst_timeout", {31'b0, timeout}, 0);
        nxt(); smp();
        chk("t6_m0_after_rst", {30'b0, grant}, 1);
        nxt();
        mcyc[0] = 0; mstb[0] = 0; mcyc[1] = 0; mstb[1] = 0;
        nxt(); nxt();
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Two-master, one-slave Wishbone (classic, pipelined-stall style) bus arbiter with round-robin fairness and a per-transfer watchdog. It sits between the platform's master interfaces (core master plus a second master such as a DMA or debug port) and the shared slave-side bus feeding the address decoder and slaves. It sequences bus ownership, muxes the granted master onto the slave port, and aborts transfers the slave never answers.

## Interface
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- SEL_WIDTH, DATA_WIDTH/8, byte-select width.
- TIMEOUT, 255, cycles a strobe may wait for ack/err before abort; must be ≥ 2.

Ports:
- wb_clk  in  1  bus clock; all logic on rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- m0_wb_cyc / m1_wb_cyc  in  1  master bus-cycle request and hold.
- m0_wb_stb / m1_wb_stb  in  1  master strobe.
- m0_wb_we / m1_wb_we  in  1  master write enable.
- m0_wb_adr / m1_wb_adr  in  ADDR_WIDTH  master address.
- m0_wb_dat_i / m1_wb_dat_i  in  DATA_WIDTH  write data from master.
- m0_wb_sel / m1_wb_sel  in  SEL_WIDTH  master byte selects.
- m0_wb_dat_o / m1_wb_dat_o  out  DATA_WIDTH  read data to master.
- m0_wb_ack / m1_wb_ack  out  1  ack to master.
- m0_wb_err / m1_wb_err  out  1  error to master.
- m0_wb_stall / m1_wb_stall  out  1  stall to master.
- s_wb_cyc, s_wb_stb, s_wb_we  out  1  slave-side controls.
- s_wb_adr  out  ADDR_WIDTH; s_wb_dat_o  out  DATA_WIDTH; s_wb_sel  out  SEL_WIDTH.
- s_wb_dat_i  in  DATA_WIDTH; s_wb_ack, s_wb_err, s_wb_stall  in  1  slave responses.
- grant  out  2  one-hot owner (bit0 = m0, bit1 = m1); 00 when none.
- timeout  out  1  one-cycle pulse when the watchdog aborts.

## Operation
- States: IDLE, OWN0, OWN1, ABORT. Registers: state, rr_ptr (1 = m1 preferred), wd_cnt (width clog2(TIMEOUT+1)), abort_owner.
- IDLE: one cyc high → own that master; both high → own master rr_ptr selects. None → stay.
- OWNx: slave outputs = master x inputs; s_wb_cyc = mx_wb_cyc; mx_wb_dat_o = s_wb_dat_i; mx_wb_ack/err/stall = slave's. Non-owner: stall=1, ack=0, err=0, dat_o=0.
- OWNx release: mx_wb_cyc low → rr_ptr := other master. If other cyc high, go directly to OWN(other), else IDLE.
- Watchdog: in OWNx, wd_cnt increments each cycle with s_wb_stb & ~s_wb_ack & ~s_wb_err. It clears on ack, err, or state change. If it would reach TIMEOUT → ABORT, abort_owner := x, timeout pulses, mx_wb_err pulses for one cycle (the first ABORT cycle).
- ABORT: s_wb_cyc = s_wb_stb = 0. Owner sees stall=1 and ack=0; err is high only in the first cycle. Slave responses are dropped. Owner cyc low → IDLE, rr_ptr := other.
- Slave outputs in IDLE/ABORT: cyc, stb, we, adr, dat_o, sel all 0.
- wb_rst mid-transfer: state IDLE, rr_ptr 0, wd_cnt 0, grant 00, timeout 0. All slave outputs 0, all master acks/errs 0, both master stalls 1. Any in-flight transfer is abandoned without ack.

## Timing
- Grant latency: cyc sampled high at edge k → grant and s_wb_cyc valid in cycle k+1. The master sees stall=1 until then.
- Response path: ack, err, stall and read data pass combinationally, owner ↔ slave, with zero added latency. Request path is also combinational once granted.
- Handover: owner drops cyc in cycle k, so s_wb_cyc is low in cycle k. The new owner drives the slave from cycle k+1. There is always ≥1 cycle with s_wb_cyc low between owners.
- Simultaneous first request from reset: m0 wins (rr_ptr = 0).
- Owner holding cyc keeps the bus indefinitely. There is no preemption, and the watchdog only counts unanswered strobes.
- Abort: the TIMEOUT-th consecutive unanswered strobe cycle is cycle k. err and timeout are high in cycle k+1 and s_wb_cyc is low from k+1.
- A slave ack arriving in the same cycle the count would hit TIMEOUT wins: normal ack, no abort.

## Test plan
- Single master: m0 writes 0xDEADBEEF to 0x10 with an immediate-ack slave → grant=01 one cycle after cyc; s_wb_dat_o=0xDEADBEEF; m0 ack same cycle as s_wb_ack; m1_wb_stall=1 throughout.
- Simultaneous requests after reset, both doing one read each → m0 served first, then exactly one idle cycle on s_wb_cyc, then m1. Read data 0x12345678 is returned only on m1_wb_dat_o.
- Fairness: both masters hold repeated back-to-back cycles ×4 → grant alternates 01,10,01,10.
- Watchdog with TIMEOUT=4: slave never acks m1 strobe → m1_wb_err and timeout high exactly on the 5th cycle after stb, for one cycle. s_wb_cyc=0 from then on. A late s_wb_ack is not forwarded. After m1 drops cyc, m0 can win.
- Ack on boundary with TIMEOUT=4: slave acks on the 4th stalled cycle → normal ack, timeout stays 0.
- wb_rst asserted mid-read while owning OWN1 → next cycle grant=00, s_wb_cyc=0, both stalls 1, m1 ack 0. After reset drops with both requesting, m0 is granted.
